// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage placed directly after the PC register.
//
// Requests instructions in order over a req/gnt handshake and accepts
// in-order, variable-latency responses. {pc, instr} pairs are buffered in a
// DEPTH-entry circular queue and handed to decode with first-word
// fall-through. pc_advance tells the next-PC logic to step the PC, and it is
// only raised when a fetch is granted. A redirect (flush_i) discards everything
// that is queued. It also arranges for responses still in flight to be dropped
// when they return.
//
// Handshakes: a transfer happens on a rising edge where both sides are high
// (imem_req && imem_gnt, instr_valid && instr_ready). The sender holds its
// payload stable until that edge. imem_rvalid is a one-cycle strobe with no
// back-pressure.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   fetch_pc          current PC from the program counter
//   pc_advance        1 = step the PC by 4 at this edge
//   flush_i           redirect: drop queued and in-flight fetches
//   imem_req/addr/gnt request channel to instruction memory
//   imem_rvalid/rdata response channel (in order, >=1 cycle after grant)
//   instr_valid/instr/instr_pc/instr_ready  head entry to decode
module fetch_unit #(
  parameter int N     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] fetch_pc,
  output logic         pc_advance,
  input  logic         flush_i,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_gnt,
  input  logic         imem_rvalid,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr,
  output logic [N-1:0] instr_pc,
  input  logic         instr_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  // Entry storage. The queue runs alloc -> fill -> head.
  logic [N-1:0]     pc_q    [DEPTH];
  logic [N-1:0]     instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [PW-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0] fill_ptr_q,  fill_ptr_d;
  logic [PW-1:0] head_ptr_q,  head_ptr_d;

  // alloc_count: entries holding a live fetch (unfilled or filled).
  // inflight:    granted requests whose response has not yet returned.
  // discard:     how many of those in-flight responses belong to a flushed path.
  logic [CW-1:0] alloc_count_q, alloc_count_d;
  logic [CW-1:0] inflight_q,    inflight_d;
  logic [CW-1:0] discard_q,     discard_d;

  logic grant;
  logic rsp;
  logic drop;
  logic fill_en;
  logic pop;

  // Issue. The limit uses the registered count, so a pop frees its slot
  // only from the next cycle on.
  assign imem_req   = !reset && !flush_i && (alloc_count_q < CW'(DEPTH));
  assign imem_addr  = fetch_pc;
  assign grant      = imem_req && imem_gnt;
  assign pc_advance = grant;

  // Responses that arrive with nothing outstanding are stray and are ignored.
  assign rsp     = imem_rvalid && (inflight_q != '0);
  assign drop    = rsp && (discard_q != '0);
  assign fill_en = rsp && !drop && !flush_i;

  // Output from the head entry, first-word fall-through.
  assign instr_valid = !reset && !flush_i && (alloc_count_q != '0) &&
                       filled_q[head_ptr_q];
  assign instr       = instr_q[head_ptr_q];
  assign instr_pc    = pc_q[head_ptr_q];
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    filled_d      = filled_q;
    alloc_ptr_d   = alloc_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    head_ptr_d    = head_ptr_q;
    alloc_count_d = alloc_count_q;
    inflight_d    = inflight_q;
    discard_d     = discard_q;

    if (flush_i) begin
      // Everything still in flight belongs to the old path. A response
      // arriving in this cycle is already dropped, so it is not counted.
      filled_d      = '0;
      alloc_ptr_d   = '0;
      fill_ptr_d    = '0;
      head_ptr_d    = '0;
      alloc_count_d = '0;
      inflight_d    = inflight_q - CW'(rsp);
      discard_d     = inflight_q - CW'(rsp);
    end else begin
      // Pop, fill and grant always touch different entries. Pop frees the
      // oldest entry. Fill targets an allocated but unfilled entry. Grant
      // targets a free slot.
      if (pop) begin
        filled_d[head_ptr_q] = 1'b0;
        head_ptr_d           = head_ptr_q + PW'(1);
      end
      if (fill_en) begin
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + PW'(1);
      end
      if (grant) begin
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + PW'(1);
      end
      alloc_count_d = alloc_count_q + CW'(grant) - CW'(pop);
      inflight_d    = inflight_q + CW'(grant) - CW'(rsp);
      discard_d     = discard_q - CW'(drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filled_q      <= '0;
      alloc_ptr_q   <= '0;
      fill_ptr_q    <= '0;
      head_ptr_q    <= '0;
      alloc_count_q <= '0;
      inflight_q    <= '0;
      discard_q     <= '0;
    end else begin
      filled_q      <= filled_d;
      alloc_ptr_q   <= alloc_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      head_ptr_q    <= head_ptr_d;
      alloc_count_q <= alloc_count_d;
      inflight_q    <= inflight_d;
      discard_q     <= discard_d;
    end
  end

  // Payload storage is cleared on reset so instr/instr_pc read zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      if (grant) begin
        pc_q[alloc_ptr_q] <= fetch_pc;
      end
      if (fill_en) begin
        instr_q[fill_ptr_q] <= imem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int N     = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [N-1:0] fetch_pc;
  logic         pc_advance;
  logic         flush_i;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  logic [N-1:0] imem_rdata;
  logic         instr_valid;
  logic [N-1:0] instr;
  logic [N-1:0] instr_pc;
  logic         instr_ready;

  fetch_unit #(.N(N), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_pc    (fetch_pc),
    .pc_advance  (pc_advance),
    .flush_i     (flush_i),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Reference model in terms of fetches, not slots:
  //   pend_q       PCs granted and still awaited (not on a flushed path)
  //   exp_pc_q/exp_q  completed {pc, instr} pairs waiting for decode
  //   discard      responses still owed to a flushed path
  logic [N-1:0] pend_q[$];
  logic [N-1:0] exp_pc_q[$];
  logic [N-1:0] exp_q[$];
  int           discard = 0;

  // Memory model: in-order responses at a scheduled cycle.
  int           mem_due[$];
  logic [N-1:0] mem_addr_q[$];
  int           last_due = 0;

  logic [N-1:0] pc_reg      = '0;
  logic [N-1:0] redirect_pc = '0;
  bit           after_reset = 1'b0;

  function automatic logic [N-1:0] instr_of(input logic [N-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit fl, input int gnt_pct,
                      input int rdy_pct, input int lat_lo, input int lat_hi);
    bit e_req, e_valid, e_grant, rsp;
    int inflight, d;
    @(negedge clk);
    reset       = rst;
    flush_i     = fl;
    imem_gnt    = ($urandom_range(99) < gnt_pct);
    instr_ready = ($urandom_range(99) < rdy_pct);
    fetch_pc    = pc_reg;
    if (mem_due.size() > 0 && mem_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_addr_q[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #1;
    inflight = discard + pend_q.size();
    e_req    = !rst && !fl && ((pend_q.size() + exp_q.size()) < DEPTH);
    e_valid  = !rst && !fl && (exp_q.size() > 0);
    e_grant  = e_req && imem_gnt;
    check("imem_req",    N'(imem_req),    N'(e_req));
    check("pc_advance",  N'(pc_advance),  N'(e_grant));
    check("imem_addr",   imem_addr,       pc_reg);
    check("instr_valid", N'(instr_valid), N'(e_valid));
    if (e_valid) begin
      check("instr",    instr,    exp_q[0]);
      check("instr_pc", instr_pc, exp_pc_q[0]);
    end
    if (after_reset) begin
      check("instr_after_reset",    instr,    '0);
      check("instr_pc_after_reset", instr_pc, '0);
    end
    @(posedge clk);
    rsp = imem_rvalid && (inflight > 0);
    // memory side
    if (imem_rvalid) begin
      void'(mem_due.pop_front());
      void'(mem_addr_q.pop_front());
    end
    if (e_grant) begin
      d = cyc + $urandom_range(lat_hi, lat_lo);
      if (d < last_due) d = last_due;
      last_due = d;
      mem_due.push_back(d);
      mem_addr_q.push_back(pc_reg);
    end
    // fetch model
    if (rst) begin
      pend_q.delete(); exp_q.delete(); exp_pc_q.delete();
      discard = 0;
    end else if (fl) begin
      discard = discard + pend_q.size() - (rsp ? 1 : 0);
      pend_q.delete(); exp_q.delete(); exp_pc_q.delete();
    end else begin
      if (e_valid && instr_ready) begin
        void'(exp_q.pop_front());
        void'(exp_pc_q.pop_front());
      end
      if (rsp) begin
        if (discard > 0) discard--;
        else begin
          exp_pc_q.push_back(pend_q.pop_front());
          exp_q.push_back(imem_rdata);
        end
      end
      if (e_grant) pend_q.push_back(pc_reg);
    end
    // next-PC logic
    if (rst || fl) pc_reg = redirect_pc;
    else if (e_grant) pc_reg = pc_reg + 32'd4;
    after_reset = rst;
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; flush_i = 1'b0; fetch_pc = '0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

    redirect_pc = 32'h0;
    repeat (3) step(1, 0, 100, 100, 1, 1);

    // back-to-back fetch from 0x0
    repeat (20) step(0, 0, 100, 100, 1, 1);

    // full queue with decode stalled, then single pops
    repeat (8) step(0, 0, 100, 0, 1, 1);
    step(0, 0, 100, 100, 1, 1);
    repeat (3) step(0, 0, 100, 0, 1, 1);
    repeat (10) step(0, 0, 100, 100, 1, 1);

    // stall at 0x100 then latency 5
    redirect_pc = 32'h100;
    step(0, 1, 0, 100, 5, 5);
    repeat (3) step(0, 0, 0, 100, 5, 5);
    repeat (20) step(0, 0, 100, 100, 5, 5);

    // flush with fetches queued and in flight, refetch from 0x200
    repeat (3) step(0, 0, 100, 0, 2, 2);
    redirect_pc = 32'h200;
    step(0, 1, 100, 0, 2, 2);
    repeat (20) step(0, 0, 100, 100, 1, 3);

    // flush coinciding with a response while three are in flight
    repeat (10) step(0, 0, 0, 100, 1, 1);
    repeat (3) step(0, 0, 100, 0, 3, 3);
    redirect_pc = 32'h300;
    step(0, 1, 100, 0, 3, 3);
    repeat (20) step(0, 0, 100, 100, 1, 2);

    // reset mid-stream with the queue holding entries, stray responses after
    repeat (10) step(0, 0, 0, 100, 1, 1);
    repeat (3) step(0, 0, 100, 0, 4, 4);
    repeat (2) step(0, 0, 0, 0, 4, 4);
    redirect_pc = 32'h400;
    step(1, 0, 100, 0, 4, 4);
    repeat (6) step(0, 0, 0, 100, 1, 1);
    repeat (20) step(0, 0, 100, 100, 1, 2);

    // randomized segments
    for (int seg = 0; seg < 30; seg++) begin
      int g, r, lo, hi;
      g  = $urandom_range(100, 20);
      r  = $urandom_range(100, 10);
      lo = $urandom_range(3, 1);
      hi = lo + $urandom_range(4, 0);
      for (int i = 0; i < 60; i++) begin
        bit fl, rs;
        fl = ($urandom_range(99) < 4);
        rs = ($urandom_range(999) < 5);
        if (fl || rs) redirect_pc = $urandom & 32'hFFFF_FFFC;
        step(rs, fl, g, r, lo, hi);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
